wb_initiator: RTL and testbench

- Single-outstanding Wishbone classic-cycle bus master.
- Converts a valid/ready command stream into one Wishbone read or write per command, and returns data or error on a valid/ready response stream.
- Sits in front of the on-chip Wishbone slaves (AES core and future peripherals) so on-chip logic and test sequencers can drive them without the management SoC.
- Includes an ack timeout, so an unresponsive slave cannot hang the initiator.

---
 rtl/wb_initiator_if.sv | 42 ++++
 rtl/wb_initiator.sv | 143 ++++++++++++++
 tb/tb_wb_initiator.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_initiator_if.sv
// Bundle of the command, response and Wishbone signals of wb_initiator.
// The master modport is the initiator's view. The slave modport is the view of
// whatever drives commands, consumes responses and models the Wishbone target.
interface wb_initiator_if #(
  parameter int ADDR_W = 28
);
  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_sel;
  logic [31:0]       cmd_data;
  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  // Wishbone classic bus
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [31:0]       wbm_dat_o;
  logic              wbm_ack_i;
  logic [31:0]       wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_data, rsp_ready,
           wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_sel, cmd_data, rsp_ready,
           wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator.
// Turns each accepted command into one read or write cycle and returns the read
// data, or a timeout error, on the response stream. Every output is registered.
module wb_initiator #(
  parameter int ADDR_W  = 28,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_initiator_if.master  bus,
  output logic [7:0]      timeout_cnt
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [15:0]       timer_q, timer_d;
  logic [7:0]        tcnt_q, tcnt_d;

  // State and output registers; reset drops the bus cycle without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      timer_q     <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      timer_q     <= timer_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Next-state and next-output logic; every register holds unless a case changes it.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    timer_d     = timer_q;
    tcnt_d      = tcnt_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          we_d        = bus.cmd_we;
          adr_d       = bus.cmd_addr;
          sel_d       = bus.cmd_sel;
          dat_d       = bus.cmd_data;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          timer_d     = '0;
          state_d     = BUS;
        end
      end

      BUS: begin
        // Ack is tested first so it beats a timeout expiring on the same edge.
        if (bus.wbm_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_data_d  = we_q ? '0 : bus.wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 8'd1;
          end
          state_d     = RESP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 16'd1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: random and directed commands against a transaction
// level model, a Wishbone slave model with chosen ack delay, and a response
// scoreboard. A second instance with the timeout disabled checks a very slow ack.
module tb_wb_initiator;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_initiator_if #(.ADDR_W(28)) b0 ();
  wb_initiator_if #(.ADDR_W(28)) b1 ();
  logic [7:0] tcnt0, tcnt1;

  wb_initiator #(.ADDR_W(28), .TIMEOUT(TO)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .timeout_cnt(tcnt0));
  wb_initiator #(.ADDR_W(28), .TIMEOUT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .timeout_cnt(tcnt1));

  typedef struct {
    logic        we;
    logic [27:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          k;
    int          acc;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [7:0]  tcnt;
    int          lat;
    int          acc;
  } rsp_t;

  txn_t slq[$];
  rsp_t sbq[$];
  int   checks = 0;
  int   passed = 0;
  int   mtcnt  = 0;
  bit   skip_dur = 1'b0;
  bit   in_rsp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Wishbone slave: acks on strobe cycle k of each transaction, random stray acks otherwise.
  int   sn = 0;
  txn_t cur;
  always @(negedge clk) begin
    if (b0.wbm_stb_o) begin
      if (sn == 0) begin
        if (slq.size() == 0) begin
          chk("unexpected_stb", 32'd1, 32'd0);
          cur = '{we: 1'b0, adr: '0, sel: '0, wdat: '0, rdat: '0, k: 0, acc: 0};
        end else begin
          cur = slq.pop_front();
          chk("stb_rise_cycle", cyc_n, cur.acc);
        end
      end
      chk("bus_adr", {4'd0, b0.wbm_adr_o}, {4'd0, cur.adr});
      chk("bus_dat", b0.wbm_dat_o, cur.wdat);
      chk("bus_we_sel_cyc", {27'd0, b0.wbm_cyc_o, b0.wbm_we_o, b0.wbm_sel_o},
          {27'd0, 1'b1, cur.we, cur.sel});
      sn++;
      b0.wbm_ack_i = (sn == cur.k);
      b0.wbm_dat_i = (sn == cur.k) ? cur.rdat : $urandom;
    end else begin
      if (sn != 0 && !skip_dur)
        chk("stb_cycles", sn, (cur.k <= TO) ? cur.k : TO);
      sn = 0;
      b0.wbm_ack_i = ($urandom_range(0, 3) == 0);
      b0.wbm_dat_i = $urandom;
    end
  end

  // Response monitor: pops the scoreboard on each new response, checks hold and handshake.
  bit   hs = 1'b0;
  rsp_t exp_r;
  always @(negedge clk) begin
    if (hs) begin
      chk("rsp_valid_drop", {31'd0, b0.rsp_valid}, 32'd0);
      chk("cmd_ready_after_hs", {31'd0, b0.cmd_ready}, 32'd1);
      in_rsp = 1'b0;
    end else if (in_rsp) begin
      chk("rsp_hold_valid", {31'd0, b0.rsp_valid}, 32'd1);
      chk("rsp_hold_data", b0.rsp_data, exp_r.data);
      chk("rsp_hold_err", {31'd0, b0.rsp_err}, {31'd0, exp_r.err});
    end else if (b0.rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_r = sbq.pop_front();
        chk("rsp_data", b0.rsp_data, exp_r.data);
        chk("rsp_err", {31'd0, b0.rsp_err}, {31'd0, exp_r.err});
        chk("timeout_cnt", {24'd0, tcnt0}, {24'd0, exp_r.tcnt});
        chk("rsp_latency", cyc_n - exp_r.acc, exp_r.lat);
        in_rsp = 1'b1;
      end
    end
    b0.rsp_ready = ($urandom_range(0, 1) == 1);
    hs = in_rsp && b0.rsp_ready;
  end

  // Presents t once cmd_ready is seen; junk commands while busy must be ignored.
  task automatic send(input txn_t t, input bit expect_rsp);
    rsp_t r;
    int   g = 0;
    forever begin
      @(negedge clk);
      if (++g > 1000) begin
        chk("cmd_accept_wait", 32'd0, 32'd1);
        return;
      end
      b0.cmd_we   = $urandom_range(0, 1);
      b0.cmd_addr = 28'($urandom);
      b0.cmd_sel  = 4'($urandom);
      b0.cmd_data = $urandom;
      if (!b0.cmd_ready) begin
        b0.cmd_valid = $urandom_range(0, 1);
      end else if ($urandom_range(0, 3) == 0) begin
        b0.cmd_valid = 1'b0;
      end else begin
        b0.cmd_valid = 1'b1;
        b0.cmd_we    = t.we;
        b0.cmd_addr  = t.adr;
        b0.cmd_sel   = t.sel;
        b0.cmd_data  = t.wdat;
        t.acc = cyc_n + 1;
        slq.push_back(t);
        if (expect_rsp) begin
          if (t.k <= TO) begin
            r.data = t.we ? 32'd0 : t.rdat;
            r.err  = 1'b0;
            r.lat  = t.k;
          end else begin
            r.data = 32'd0;
            r.err  = 1'b1;
            r.lat  = TO;
            if (mtcnt < 255) mtcnt++;
          end
          r.tcnt = 8'(mtcnt);
          r.acc  = t.acc;
          sbq.push_back(r);
        end
        return;
      end
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [27:0] adr, input logic [3:0] sel,
                              input logic [31:0] wdat, input logic [31:0] rdat, input int k);
    txn_t t;
    t.we = we; t.adr = adr; t.sel = sel; t.wdat = wdat; t.rdat = rdat; t.k = k; t.acc = 0;
    return t;
  endfunction

  task automatic run_random(input int count, input int kmin, input int kmax);
    for (int i = 0; i < count; i++)
      send(mk($urandom_range(0, 1), 28'($urandom), 4'($urandom), $urandom, $urandom,
              $urandom_range(kmin, kmax)), 1'b1);
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk) b0.cmd_valid = 1'b0;
    while ((sbq.size() != 0 || in_rsp) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) chk("drain_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lost;
    b0.cmd_valid = 1'b0; b0.cmd_we = 1'b0; b0.cmd_addr = '0; b0.cmd_sel = '0; b0.cmd_data = '0;
    b1.cmd_valid = 1'b0; b1.cmd_we = 1'b0; b1.cmd_addr = '0; b1.cmd_sel = '0; b1.cmd_data = '0;
    b1.rsp_ready = 1'b0; b1.wbm_ack_i = 1'b0; b1.wbm_dat_i = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, b0.cmd_ready}, 32'd0);
    chk("rst_rsp", {29'd0, b0.rsp_valid, b0.rsp_err, |b0.rsp_data}, 32'd0);
    chk("rst_bus", {28'd0, b0.wbm_cyc_o, b0.wbm_stb_o, b0.wbm_we_o, |b0.wbm_sel_o}, 32'd0);
    chk("rst_adr_dat", {4'd0, b0.wbm_adr_o} | b0.wbm_dat_o, 32'd0);
    chk("rst_tcnt", {24'd0, tcnt0}, 32'd0);
    rst_n = 1'b1;
    #1 chk("cmd_ready_before_edge", {31'd0, b0.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("cmd_ready_first_edge", {31'd0, b0.cmd_ready}, 32'd1);

    // directed: write, read, timeout, ack-on-expiry, one past expiry
    send(mk(1'b1, 28'h0000010, 4'hF, 32'hA5A5_1234, 32'h1111_2222, 2), 1'b1);
    send(mk(1'b0, 28'h0000020, 4'hF, 32'h0, 32'hDEAD_BEEF, 1), 1'b1);
    send(mk(1'b0, 28'h0000030, 4'h3, 32'h0, 32'h5555_AAAA, 99), 1'b1);
    send(mk(1'b0, 28'h0000040, 4'hC, 32'h0, 32'h1234_5678, TO), 1'b1);
    send(mk(1'b1, 28'h0000050, 4'h1, 32'h7777_8888, 32'h0, TO + 1), 1'b1);

    run_random(150, 1, 7);
    run_random(260, 99, 99);
    run_random(5, 1, 3);
    drain();
    chk("tcnt_saturated", {24'd0, tcnt0}, 32'd255);

    // reset during the second strobe cycle
    send(mk(1'b1, 28'h0000060, 4'hF, 32'hCAFE_F00D, 32'h0, 99), 1'b0);
    @(negedge clk) b0.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_stb", {31'd0, b0.wbm_stb_o}, 32'd1);
    skip_dur = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc_stb", {30'd0, b0.wbm_cyc_o, b0.wbm_stb_o}, 32'd0);
    chk("async_rst_ready_valid", {30'd0, b0.cmd_ready, b0.rsp_valid}, 32'd0);
    chk("async_rst_tcnt", {24'd0, tcnt0}, 32'd0);
    mtcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'd0, b0.cmd_ready}, 32'd1);
    lost = 0;
    for (int i = 0; i < 8; i++) begin
      if (b0.rsp_valid) lost++;
      @(negedge clk);
    end
    chk("no_rsp_after_rst", lost, 32'd0);
    skip_dur = 1'b0;
    run_random(10, 1, 6);
    drain();

    // timeout disabled: ack after 1000 strobe cycles completes normally
    lost = 0;
    while (!b1.cmd_ready && lost < 20) begin
      @(negedge clk);
      lost++;
    end
    chk("t0_cmd_ready", {31'd0, b1.cmd_ready}, 32'd1);
    b1.cmd_valid = 1'b1; b1.cmd_we = 1'b0; b1.cmd_addr = 28'h0ABCDE0; b1.cmd_sel = 4'hF;
    @(negedge clk) b1.cmd_valid = 1'b0;
    lost = 0;
    for (int i = 1; i < 1000; i++) begin
      if (!b1.wbm_stb_o) lost++;
      @(negedge clk);
    end
    chk("t0_stb_held", lost, 32'd0);
    chk("t0_stb_1000", {31'd0, b1.wbm_stb_o}, 32'd1);
    b1.wbm_ack_i = 1'b1; b1.wbm_dat_i = 32'hC0FF_EE00; b1.rsp_ready = 1'b1;
    @(negedge clk) b1.wbm_ack_i = 1'b0;
    chk("t0_rsp_valid", {31'd0, b1.rsp_valid}, 32'd1);
    chk("t0_rsp_data", b1.rsp_data, 32'hC0FF_EE00);
    chk("t0_rsp_err_cyc", {30'd0, b1.rsp_err, b1.wbm_cyc_o}, 32'd0);
    chk("t0_tcnt", {24'd0, tcnt1}, 32'd0);
    @(negedge clk);
    chk("t0_one_cycle_valid", {30'd0, b1.rsp_valid, b1.cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
